// File: rtl/snake_pkg.sv
// Shared encodings for the two-player snake step sequencer: headings, grid
// field widths, reset coordinates and the step FSM states.
package snake_pkg;

    localparam int X_W   = 5;
    localparam int Y_W   = 5;
    localparam int SEG_W = X_W + Y_W;

    localparam logic [X_W-1:0] GRID_MASK = '1;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Initial body placement: snake 1 trails left of its head, snake 2 trails right.
    localparam logic [X_W-1:0] S1_X0 = 5'd4;
    localparam logic [Y_W-1:0] S1_Y  = 5'd16;
    localparam logic [X_W-1:0] S2_X0 = 5'd27;
    localparam logic [Y_W-1:0] S2_Y  = 5'd15;
    localparam int             SEED_SEGS = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_SCAN,
        ST_COMMIT,
        ST_DONE
    } state_t;

    // Opposite headings differ only in bit 0 within each axis pair.
    function automatic logic is_reverse(input dir_t cur, input logic [1:0] req);
        return req == {cur[1], ~cur[0]};
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Steps a packed head one cell along a heading on the 32x32 torus grid.
module snake_next_head
    import snake_pkg::*;
(
    input  logic [SEG_W-1:0] head,
    input  dir_t             dir,
    output logic [SEG_W-1:0] next_head
);

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;

    assign x = head[SEG_W-1:Y_W];
    assign y = head[Y_W-1:0];

    always_comb begin
        nx = x;
        ny = y;
        case (dir)
            DIR_UP:    ny = (y - Y_W'(1)) & GRID_MASK;
            DIR_DOWN:  ny = (y + Y_W'(1)) & GRID_MASK;
            DIR_LEFT:  nx = (x - X_W'(1)) & GRID_MASK;
            DIR_RIGHT: nx = (x + X_W'(1)) & GRID_MASK;
            default:   nx = x;
        endcase
        next_head = {nx, ny};
    end

endmodule

// File: rtl/snake_step_ctrl.sv
// Two-player snake step sequencer: head update, serial collision scan, commit.
// Define SNAKE_SELF_COLLIDE_EN to also flag a head running into its own body.
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int NUM_LEN  = 10,
    parameter int LEN_W    = 5,
    parameter int INIT_LEN = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       clear,
    input  logic [1:0]                 dir1,
    input  logic [1:0]                 dir2,
    input  logic                       grow1,
    input  logic                       grow2,
    output logic [MAX_LEN*NUM_LEN-1:0] snake1,
    output logic [MAX_LEN*NUM_LEN-1:0] snake2,
    output logic [LEN_W-1:0]           len1,
    output logic [LEN_W-1:0]           len2,
    output logic                       busy,
    output logic                       step_done,
    output logic                       should_stop1,
    output logic                       should_stop2
);

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);

    state_t             state;
    dir_t               heading1, heading2;
    dir_t               eff1, eff2;
    logic [NUM_LEN-1:0] h1, h2;
    logic [NUM_LEN-1:0] nh1, nh2;
    logic               hit1, hit2;
    logic               scan_hit1, scan_hit2;
    logic               grow1_q, grow2_q;
    logic [LEN_W-1:0]   idx, scan_n;

    function automatic logic [MAX_LEN*NUM_LEN-1:0] init_body(
        input logic [X_W-1:0] x0,
        input logic [Y_W-1:0] y,
        input logic           tail_right
    );
        logic [MAX_LEN*NUM_LEN-1:0] v;
        logic [X_W-1:0]             xi;
        v = '0;
        for (int unsigned i = 0; i < SEED_SEGS; i++) begin
            xi = tail_right ? x0 + X_W'(i) : x0 - X_W'(i);
            v[i*NUM_LEN +: NUM_LEN] = NUM_LEN'({xi, y});
        end
        return v;
    endfunction

    always_comb begin
        eff1 = is_reverse(heading1, dir1) ? heading1 : dir_t'(dir1);
        eff2 = is_reverse(heading2, dir2) ? heading2 : dir_t'(dir2);
    end

    snake_next_head u_head1 (
        .head      (snake1[NUM_LEN-1:0]),
        .dir       (eff1),
        .next_head (nh1)
    );

    snake_next_head u_head2 (
        .head      (snake2[NUM_LEN-1:0]),
        .dir       (eff2),
        .next_head (nh2)
    );

    // One segment per cycle: the loop only decodes idx into a segment mux.
    always_comb begin
        scan_hit1 = 1'b0;
        scan_hit2 = 1'b0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (idx == LEN_W'(i)) begin
                if (idx < len2 && h1 == snake2[i*NUM_LEN +: NUM_LEN]) scan_hit1 = 1'b1;
                if (idx < len1 && h2 == snake1[i*NUM_LEN +: NUM_LEN]) scan_hit2 = 1'b1;
`ifdef SNAKE_SELF_COLLIDE_EN
                if (({1'b0, idx} + (LEN_W+1)'(1)) < {1'b0, len1} &&
                    h1 == snake1[i*NUM_LEN +: NUM_LEN]) scan_hit1 = 1'b1;
                if (({1'b0, idx} + (LEN_W+1)'(1)) < {1'b0, len2} &&
                    h2 == snake2[i*NUM_LEN +: NUM_LEN]) scan_hit2 = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            snake1       <= init_body(S1_X0, S1_Y, 1'b0);
            snake2       <= init_body(S2_X0, S2_Y, 1'b1);
            len1         <= LEN_INIT;
            len2         <= LEN_INIT;
            heading1     <= DIR_RIGHT;
            heading2     <= DIR_LEFT;
            busy         <= 1'b0;
            step_done    <= 1'b0;
            should_stop1 <= 1'b0;
            should_stop2 <= 1'b0;
            h1           <= '0;
            h2           <= '0;
            hit1         <= 1'b0;
            hit2         <= 1'b0;
            grow1_q      <= 1'b0;
            grow2_q      <= 1'b0;
            idx          <= '0;
            scan_n       <= '0;
        end else if (clear) begin
            state        <= ST_IDLE;
            snake1       <= init_body(S1_X0, S1_Y, 1'b0);
            snake2       <= init_body(S2_X0, S2_Y, 1'b1);
            len1         <= LEN_INIT;
            len2         <= LEN_INIT;
            heading1     <= DIR_RIGHT;
            heading2     <= DIR_LEFT;
            busy         <= 1'b0;
            step_done    <= 1'b0;
            should_stop1 <= 1'b0;
            should_stop2 <= 1'b0;
            h1           <= '0;
            h2           <= '0;
            hit1         <= 1'b0;
            hit2         <= 1'b0;
            grow1_q      <= 1'b0;
            grow2_q      <= 1'b0;
            idx          <= '0;
            scan_n       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick && !should_stop1 && !should_stop2) begin
                        state   <= ST_MOVE;
                        busy    <= 1'b1;
                        grow1_q <= grow1;
                        grow2_q <= grow2;
                        hit1    <= 1'b0;
                        hit2    <= 1'b0;
                    end
                end
                ST_MOVE: begin
                    heading1 <= eff1;
                    heading2 <= eff2;
                    h1       <= nh1;
                    h2       <= nh2;
                    hit1     <= (nh1 == nh2);
                    hit2     <= (nh1 == nh2);
                    idx      <= '0;
                    scan_n   <= (len1 > len2) ? len1 : len2;
                    state    <= ST_SCAN;
                end
                ST_SCAN: begin
                    hit1 <= hit1 | scan_hit1;
                    hit2 <= hit2 | scan_hit2;
                    idx  <= idx + LEN_W'(1);
                    if (idx == scan_n - LEN_W'(1)) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (hit1 || hit2) begin
                        should_stop1 <= hit1;
                        should_stop2 <= hit2;
                    end else begin
                        snake1 <= {snake1[(MAX_LEN-1)*NUM_LEN-1:0], h1};
                        snake2 <= {snake2[(MAX_LEN-1)*NUM_LEN-1:0], h2};
                        if (grow1_q && len1 < LEN_MAX) len1 <= len1 + LEN_W'(1);
                        if (grow2_q && len2 < LEN_MAX) len2 <= len2 + LEN_W'(1);
                    end
                    step_done <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    step_done <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    step_done <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl: reset, stepping, reverse rejection,
// torus wrap, head-on stop, growth saturation and clear abort.
module tb_snake_step_ctrl;

    localparam int MAX_LEN = 16;
    localparam int NUM_LEN = 10;
    localparam int LEN_W   = 5;
    localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;

    logic clk = 1'b0;
    logic rst, tick, clear, grow1, grow2;
    logic [1:0] dir1, dir2;
    logic [MAX_LEN*NUM_LEN-1:0] snake1, snake2;
    logic [LEN_W-1:0] len1, len2;
    logic busy, step_done, should_stop1, should_stop2;

    logic [MAX_LEN*NUM_LEN-1:0] exp1, exp2;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    snake_step_ctrl #(
        .MAX_LEN  (MAX_LEN),
        .NUM_LEN  (NUM_LEN),
        .LEN_W    (LEN_W),
        .INIT_LEN (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .clear        (clear),
        .dir1         (dir1),
        .dir2         (dir2),
        .grow1        (grow1),
        .grow2        (grow2),
        .snake1       (snake1),
        .snake2       (snake2),
        .len1         (len1),
        .len2         (len2),
        .busy         (busy),
        .step_done    (step_done),
        .should_stop1 (should_stop1),
        .should_stop2 (should_stop2)
    );

    function automatic logic [9:0] seg(input int x, input int y);
        return {x[4:0], y[4:0]};
    endfunction

    function automatic logic [9:0] s1(input int i);
        return snake1[i*NUM_LEN +: NUM_LEN];
    endfunction

    function automatic logic [9:0] s2(input int i);
        return snake2[i*NUM_LEN +: NUM_LEN];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        next_cycle();
        clear = 1'b0;
    endtask

    // Issues one tick and waits for step_done; lat = edges after the accepting edge.
    task automatic do_tick(input logic [1:0] d1, input logic [1:0] d2,
                           input logic g1, input logic g2, output int lat);
        dir1 = d1; dir2 = d2; grow1 = g1; grow2 = g2; tick = 1'b1;
        next_cycle();
        tick = 1'b0; grow1 = 1'b0; grow2 = 1'b0;
        lat = 0;
        while (step_done !== 1'b1 && lat < 40) begin
            next_cycle();
            lat++;
        end
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; clear = 1'b0; grow1 = 1'b0; grow2 = 1'b0;
        dir1 = RIGHT; dir2 = LEFT;
        repeat (2) next_cycle();
        rst = 1'b0;
        next_cycle();
        exp1 = '0; exp2 = '0;
        exp1[9:0] = seg(4, 16);  exp1[19:10] = seg(3, 16);  exp1[29:20] = seg(2, 16);
        exp2[9:0] = seg(27, 15); exp2[19:10] = seg(28, 15); exp2[29:20] = seg(29, 15);
        total++; if (snake1 !== exp1) begin $display("FAIL reset_snake1 got=%h want=%h", snake1, exp1); bad++; end
        total++; if (snake2 !== exp2) begin $display("FAIL reset_snake2 got=%h want=%h", snake2, exp2); bad++; end
        total++; if (len1 !== 5'd3 || len2 !== 5'd3) begin $display("FAIL reset_len got=%0d/%0d want=3/3", len1, len2); bad++; end
        total++; if ({busy, step_done, should_stop1, should_stop2} !== 4'b0000) begin
            $display("FAIL reset_flags got=%b want=0000", {busy, step_done, should_stop1, should_stop2}); bad++; end
    endtask

    task automatic test_first_step();
        int lat;
        do_tick(RIGHT, LEFT, 1'b0, 1'b0, lat);
        total++; if (lat !== 5) begin $display("FAIL first_latency got=%0d want=5", lat); bad++; end
        total++; if (s1(0) !== seg(5, 16)) begin $display("FAIL first_head1 got=%h want=%h", s1(0), seg(5, 16)); bad++; end
        total++; if (s1(1) !== seg(4, 16) || s1(2) !== seg(3, 16)) begin
            $display("FAIL first_body1 got=%h,%h want=%h,%h", s1(1), s1(2), seg(4, 16), seg(3, 16)); bad++; end
        total++; if (s2(0) !== seg(26, 15) || s2(1) !== seg(27, 15)) begin
            $display("FAIL first_snake2 got=%h,%h want=%h,%h", s2(0), s2(1), seg(26, 15), seg(27, 15)); bad++; end
        total++; if (len1 !== 5'd3 || len2 !== 5'd3 || should_stop1 || should_stop2 || busy) begin
            $display("FAIL first_state got len=%0d/%0d stop=%b%b busy=%b want 3/3 00 0",
                     len1, len2, should_stop1, should_stop2, busy); bad++; end
    endtask

    task automatic test_reverse();
        int lat;
        do_clear();
        do_tick(LEFT, RIGHT, 1'b0, 1'b0, lat);
        total++; if (s1(0) !== seg(5, 16)) begin $display("FAIL reverse_head1 got=%h want=%h", s1(0), seg(5, 16)); bad++; end
        total++; if (s2(0) !== seg(26, 15)) begin $display("FAIL reverse_head2 got=%h want=%h", s2(0), seg(26, 15)); bad++; end
        do_tick(DOWN, UP, 1'b0, 1'b0, lat);
        total++; if (s1(0) !== seg(5, 17) || s2(0) !== seg(26, 14)) begin
            $display("FAIL turn_heads got=%h,%h want=%h,%h", s1(0), s2(0), seg(5, 17), seg(26, 14)); bad++; end
    endtask

    task automatic test_busy_tick();
        int lat;
        bit extra;
        do_clear();
        dir1 = RIGHT; dir2 = LEFT; tick = 1'b1;
        next_cycle();
        tick = 1'b0;
        total++; if (busy !== 1'b1) begin $display("FAIL busy_move got=%b want=1", busy); bad++; end
        next_cycle();
        tick = 1'b1;
        next_cycle();
        tick = 1'b0;
        lat = 0;
        while (step_done !== 1'b1 && lat < 40) begin next_cycle(); lat++; end
        total++; if (lat >= 40) begin $display("FAIL busy_done_timeout got=%0d want<40", lat); bad++; end
        extra = 1'b0;
        repeat (12) begin next_cycle(); if (step_done) extra = 1'b1; end
        total++; if (extra !== 1'b0) begin $display("FAIL busy_tick_queued got=%b want=0", extra); bad++; end
        total++; if (s1(0) !== seg(5, 16)) begin $display("FAIL busy_single_step got=%h want=%h", s1(0), seg(5, 16)); bad++; end
    endtask

    task automatic test_wrap();
        int lat;
        do_clear();
        for (int k = 0; k < 27; k++) begin
            do_tick(RIGHT, LEFT, 1'b0, 1'b0, lat);
            total++; if (lat !== 5) begin $display("FAIL wrap_latency step=%0d got=%0d want=5", k, lat); bad++; end
        end
        total++; if (s1(0) !== seg(31, 16) || s2(0) !== seg(0, 15)) begin
            $display("FAIL wrap_edge got=%h,%h want=%h,%h", s1(0), s2(0), seg(31, 16), seg(0, 15)); bad++; end
        do_tick(RIGHT, LEFT, 1'b0, 1'b0, lat);
        total++; if (s1(0) !== seg(0, 16) || s1(1) !== seg(31, 16)) begin
            $display("FAIL wrap_x1 got=%h,%h want=%h,%h", s1(0), s1(1), seg(0, 16), seg(31, 16)); bad++; end
        total++; if (s2(0) !== seg(31, 15)) begin $display("FAIL wrap_x2 got=%h want=%h", s2(0), seg(31, 15)); bad++; end
    endtask

    task automatic test_collision();
        int lat;
        bit moved;
        do_clear();
        do_tick(UP, LEFT, 1'b0, 1'b0, lat);
        for (int k = 0; k < 10; k++) do_tick(RIGHT, LEFT, 1'b0, 1'b0, lat);
        total++; if (s1(0) !== seg(14, 15) || s2(0) !== seg(16, 15) || should_stop1 || should_stop2) begin
            $display("FAIL approach got=%h,%h stop=%b%b want=%h,%h stop=00",
                     s1(0), s2(0), should_stop1, should_stop2, seg(14, 15), seg(16, 15)); bad++; end
        do_tick(RIGHT, LEFT, 1'b0, 1'b0, lat);
        total++; if (lat !== 5) begin $display("FAIL headon_latency got=%0d want=5", lat); bad++; end
        total++; if ({should_stop1, should_stop2} !== 2'b11) begin
            $display("FAIL headon_stops got=%b want=11", {should_stop1, should_stop2}); bad++; end
        total++; if (s1(0) !== seg(14, 15) || s2(0) !== seg(16, 15) || len1 !== 5'd3 || len2 !== 5'd3) begin
            $display("FAIL headon_frozen got=%h,%h len=%0d/%0d want=%h,%h len=3/3",
                     s1(0), s2(0), len1, len2, seg(14, 15), seg(16, 15)); bad++; end
        tick = 1'b1;
        next_cycle();
        tick = 1'b0;
        moved = 1'b0;
        repeat (8) begin if (busy || step_done) moved = 1'b1; next_cycle(); end
        total++; if (moved !== 1'b0 || s1(0) !== seg(14, 15)) begin
            $display("FAIL stopped_tick got busy_seen=%b head=%h want 0 %h", moved, s1(0), seg(14, 15)); bad++; end
        do_clear();
        total++; if ({should_stop1, should_stop2} !== 2'b00 || snake1 !== exp1) begin
            $display("FAIL clear_stops got=%b want=00", {should_stop1, should_stop2}); bad++; end
    endtask

    task automatic test_grow();
        int lat;
        int explen;
        explen = 3;
        for (int k = 0; k < 14; k++) begin
            do_tick(RIGHT, LEFT, 1'b1, 1'b0, lat);
            total++; if (lat !== explen + 2) begin $display("FAIL grow_latency step=%0d got=%0d want=%0d", k, lat, explen + 2); bad++; end
            if (explen < 16) explen++;
            total++; if (len1 !== LEN_W'(explen)) begin $display("FAIL grow_len step=%0d got=%0d want=%0d", k, len1, explen); bad++; end
        end
        total++; if (s1(0) !== seg(18, 16) || s1(1) !== seg(17, 16)) begin
            $display("FAIL grow_head got=%h,%h want=%h,%h", s1(0), s1(1), seg(18, 16), seg(17, 16)); bad++; end
        total++; if (s1(15) !== seg(3, 16)) begin $display("FAIL grow_tail got=%h want=%h", s1(15), seg(3, 16)); bad++; end
        total++; if (len2 !== 5'd3 || s2(0) !== seg(13, 15)) begin
            $display("FAIL grow_other got len=%0d head=%h want 3 %h", len2, s2(0), seg(13, 15)); bad++; end
    endtask

    task automatic test_clear_mid();
        int lat;
        bit pulsed;
        dir1 = RIGHT; dir2 = LEFT; tick = 1'b1;
        next_cycle();
        tick = 1'b0;
        next_cycle();
        tick = 1'b1;
        next_cycle();
        tick = 1'b0;
        total++; if (busy !== 1'b1) begin $display("FAIL mid_busy got=%b want=1", busy); bad++; end
        do_clear();
        total++; if (snake1 !== exp1 || snake2 !== exp2) begin
            $display("FAIL mid_clear_bodies got=%h/%h want=%h/%h", snake1, snake2, exp1, exp2); bad++; end
        total++; if (len1 !== 5'd3 || len2 !== 5'd3 || busy !== 1'b0 || step_done !== 1'b0) begin
            $display("FAIL mid_clear_state got len=%0d/%0d busy=%b done=%b want 3/3 0 0", len1, len2, busy, step_done); bad++; end
        pulsed = 1'b0;
        repeat (20) begin if (step_done) pulsed = 1'b1; next_cycle(); end
        total++; if (pulsed !== 1'b0) begin $display("FAIL mid_abort_pulse got=%b want=0", pulsed); bad++; end
        do_tick(RIGHT, LEFT, 1'b0, 1'b0, lat);
        total++; if (lat !== 5 || s1(0) !== seg(5, 16)) begin
            $display("FAIL post_clear_step got lat=%0d head=%h want 5 %h", lat, s1(0), seg(5, 16)); bad++; end
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_reverse();
        test_busy_tick();
        test_wrap();
        test_collision();
        test_grow();
        test_clear_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
